// File: rtl/tx_packet_scheduler_pkg.sv
// Shared types and constants for the TX packet scheduler.
// The optional keyboard starvation guard is enabled with TX_SCHED_STARVE_GUARD_EN.
package tx_packet_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LAUNCH     = 3'd1,
    WAIT_START = 3'd2,
    WAIT_DONE  = 3'd3,
    GAP        = 3'd4
  } tx_state_e;

  localparam logic [1:0] GRANT_NONE  = 2'd0;
  localparam logic [1:0] GRANT_PWR   = 2'd1;
  localparam logic [1:0] GRANT_AUDIO = 2'd2;
  localparam logic [1:0] GRANT_KB    = 2'd3;

  localparam logic [7:0] OP_POWER_ON = 8'hC0;
  localparam logic [7:0] OP_AUDIO    = 8'h07;
  localparam logic [7:0] OP_KB       = 8'hC5;

  // Cycles WAIT_START tolerates without send_busy before assuming the sender absorbed the packet.
  localparam int unsigned START_TIMEOUT = 8;
  localparam int unsigned START_CNT_W   = $clog2(START_TIMEOUT);
  localparam logic [START_CNT_W-1:0] START_LAST = START_CNT_W'(START_TIMEOUT - 1);

  function automatic logic [39:0] kb_packet(input logic is_mouse, input logic [15:0] data);
    return {OP_KB, 7'b0, is_mouse, data, 8'h00};
  endfunction

endpackage

// File: rtl/tx_gap_timer.sv
// Inter-packet gap countdown: load arms CYCLES, done flags the last counting cycle.
// The counter saturates at zero and never wraps.
module tx_gap_timer #(
  parameter int unsigned CYCLES = 40
) (
  input  logic mon_clk,
  input  logic reset,
  input  logic load,
  input  logic count,
  output logic done
);

  localparam int unsigned W = (CYCLES > 0) ? $clog2(CYCLES + 1) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(CYCLES);

  logic [W-1:0] remaining;

  always_ff @(posedge mon_clk) begin
    if (reset) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= LOAD_VAL;
    end else if (count && (remaining != '0)) begin
      remaining <= remaining - W'(1);
    end
  end

  assign done = count && (remaining <= W'(1));

endmodule

// File: rtl/tx_packet_scheduler.sv
// Fixed-priority scheduler launching power-on, audio and keyboard packets to a serial sender.
// Define TX_SCHED_STARVE_GUARD_EN to let a waiting keyboard word overtake repeated audio grants.
module tx_packet_scheduler
  import tx_packet_scheduler_pkg::*;
#(
  parameter int unsigned GAP_CYCLES   = 40,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        mon_clk,
  input  logic        reset,
  input  logic        audio_req,
  input  logic        power_on,
  input  logic        kb_ready,
  input  logic        kb_is_mouse,
  input  logic [15:0] kb_data,
  output logic        kb_retrieved,
  input  logic        send_busy,
  output logic [39:0] out_data,
  output logic        out_valid,
  output logic [1:0]  grant_id,
  output tx_state_e   dbg_state
);

  // Handshake: out_valid is a single-cycle strobe with out_data/grant_id already stable;
  // the sender answers with send_busy (optional) and there is no back-pressure on the strobe.

  tx_state_e state, state_nx;

  logic                   pend_pwr, pend_audio;
  logic                   kb_outstanding;
  logic                   kb_pending;
  logic                   starve_hit;
  logic [1:0]             pick;
  logic [39:0]            pick_data;
  logic [1:0]             grant_q;
  logic [39:0]            out_data_q;
  logic [START_CNT_W-1:0] start_cnt;
  logic                   gap_load, gap_count, gap_done;
  logic                   launching;

  assign kb_pending = kb_ready && !kb_outstanding;
  assign launching  = (state == LAUNCH);

`ifdef TX_SCHED_STARVE_GUARD_EN
  localparam int unsigned AGE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [AGE_W-1:0] age;

  assign starve_hit = (age >= AGE_W'(STARVE_LIMIT));

  always_ff @(posedge mon_clk) begin
    if (reset) begin
      age <= '0;
    end else if (state == IDLE) begin
      if (pick == GRANT_KB) begin
        age <= '0;
      end else if ((pick == GRANT_AUDIO) && kb_pending && !starve_hit) begin
        age <= age + AGE_W'(1);
      end
    end
  end
`else
  // Strict priority: audio always beats keyboard; STARVE_LIMIT has no effect in this build.
  assign starve_hit = 1'b0 & (STARVE_LIMIT == 0);
`endif

  always_comb begin
    pick = GRANT_NONE;
    if (pend_pwr) begin
      pick = GRANT_PWR;
    end else if (pend_audio && !(kb_pending && starve_hit)) begin
      pick = GRANT_AUDIO;
    end else if (kb_pending) begin
      pick = GRANT_KB;
    end
  end

  always_comb begin
    pick_data = '0;
    case (pick)
      GRANT_PWR:   pick_data = {OP_POWER_ON, 32'h0};
      GRANT_AUDIO: pick_data = {OP_AUDIO, 32'h0};
      GRANT_KB:    pick_data = kb_packet(kb_is_mouse, kb_data);
      default:     pick_data = '0;
    endcase
  end

  always_ff @(posedge mon_clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    gap_load  = 1'b0;
    gap_count = 1'b0;
    case (state)
      IDLE: begin
        if (pick != GRANT_NONE) state_nx = LAUNCH;
      end
      LAUNCH: begin
        state_nx = WAIT_START;
      end
      WAIT_START: begin
        if (send_busy) begin
          state_nx = WAIT_DONE;
        end else if (start_cnt == START_LAST) begin
          state_nx = GAP;
          gap_load = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!send_busy) begin
          state_nx = GAP;
          gap_load = 1'b1;
        end
      end
      GAP: begin
        gap_count = 1'b1;
        if (gap_done) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // A pulse landing in the launch cycle wins over the clear, so it is never lost.
  always_ff @(posedge mon_clk) begin
    if (reset) begin
      pend_pwr       <= 1'b0;
      pend_audio     <= 1'b0;
      kb_outstanding <= 1'b0;
      grant_q        <= GRANT_NONE;
      out_data_q     <= '0;
      start_cnt      <= '0;
    end else begin
      pend_pwr   <= power_on  | (pend_pwr   & ~(launching && (grant_q == GRANT_PWR)));
      pend_audio <= audio_req | (pend_audio & ~(launching && (grant_q == GRANT_AUDIO)));

      if ((state == IDLE) && (pick != GRANT_NONE)) begin
        out_data_q <= pick_data;
        grant_q    <= pick;
        if (pick == GRANT_KB) kb_outstanding <= 1'b1;
      end else if ((state == GAP) && gap_done) begin
        kb_outstanding <= 1'b0;
      end

      if ((state == WAIT_START) && !send_busy) begin
        start_cnt <= start_cnt + START_CNT_W'(1);
      end else begin
        start_cnt <= '0;
      end
    end
  end

  tx_gap_timer #(
    .CYCLES(GAP_CYCLES)
  ) u_gap_timer (
    .mon_clk(mon_clk),
    .reset  (reset),
    .load   (gap_load),
    .count  (gap_count),
    .done   (gap_done)
  );

  assign out_valid    = launching;
  assign kb_retrieved = launching && (grant_q == GRANT_KB);
  assign out_data     = out_data_q;
  assign grant_id     = grant_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_tx_packet_scheduler.sv
// Bench for tx_packet_scheduler: timing-rule reference model, directed scenarios, random traffic.
// Expectations follow TX_SCHED_STARVE_GUARD_EN when the build defines it.
module tb_tx_packet_scheduler;
  import tx_packet_scheduler_pkg::*;

  localparam int N     = 40;
  localparam int LIMIT = 4;

  logic        mon_clk = 1'b0;
  logic        reset, audio_req, power_on, kb_ready, kb_is_mouse, send_busy;
  logic [15:0] kb_data;
  logic        kb_retrieved, out_valid;
  logic [39:0] out_data;
  logic [1:0]  grant_id;
  tx_state_e   dbg_state;

  tx_packet_scheduler #(.GAP_CYCLES(N), .STARVE_LIMIT(LIMIT)) dut (
    .mon_clk(mon_clk), .reset(reset), .audio_req(audio_req), .power_on(power_on),
    .kb_ready(kb_ready), .kb_is_mouse(kb_is_mouse), .kb_data(kb_data),
    .kb_retrieved(kb_retrieved), .send_busy(send_busy), .out_data(out_data),
    .out_valid(out_valid), .grant_id(grant_id), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 mon_clk = ~mon_clk;

  int cyc = 0;
  always @(posedge mon_clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // Sender plan: 0 random, 1 fixed start/length, 2 never busy (start timeout).
  int plan_mode = 1;
  int plan_s    = 1;
  int plan_len  = 5;
  int busy_start = 0;
  int busy_end   = 0;

  bit kb_auto = 0;
  bit kb_pop  = 0;
  int kb_cool = 0;

  int          rec_cyc[$];
  logic [1:0]  rec_gid[$];
  logic [39:0] rec_data[$];
  logic        rec_kbr[$];
  logic [39:0] exp_q[$];

  // ---------------- reference model + compare ----------------
  bit          m_pwr = 0, m_aud = 0;
  int          m_age = 0;
  int          idle_from = 0;
  bit          exp_valid = 0;
  logic [39:0] exp_data = '0;
  logic [1:0]  exp_gid = '0;

  function automatic logic [39:0] packet_of(input logic [1:0] g, input logic mouse, input logic [15:0] d);
    if (g == 2'd1) return 40'hC0_0000_0000;
    if (g == 2'd2) return 40'h07_0000_0000;
    return {8'hC5, 7'b0, mouse, d, 8'h00};
  endfunction

  initial begin
    bit          nv;
    logic [1:0]  g;
    int          s, len;
    logic [39:0] e;
    forever begin
      @(negedge mon_clk);
      chk("out_valid", out_valid, exp_valid);
      chk("kb_retrieved", kb_retrieved, exp_valid && (exp_gid == 2'd3));
      chk("out_data", out_data, exp_data);
      chk("grant_id", grant_id, exp_gid);
      if (out_valid === 1'b1) begin
        rec_cyc.push_back(cyc);
        rec_gid.push_back(grant_id);
        rec_data.push_back(out_data);
        rec_kbr.push_back(kb_retrieved);
        if (exp_q.size() == 0) chk("launch_expected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("launch_data", out_data, e);
        end
      end

      if (exp_valid) begin
        if (exp_gid == 2'd1) m_pwr = 0;
        else if (exp_gid == 2'd2) m_aud = 0;
        else kb_pop = 1;
        if (plan_mode == 2 || (plan_mode == 0 && $urandom_range(0, 4) == 0)) begin
          busy_start = 0; busy_end = 0;
          idle_from = cyc + N + 9;
        end else begin
          s   = (plan_mode == 1) ? plan_s   : int'($urandom_range(1, 8));
          len = (plan_mode == 1) ? plan_len : int'($urandom_range(1, 20));
          busy_start = cyc + s; busy_end = cyc + s + len;
          idle_from = cyc + s + len + N + 1;
        end
      end

      nv = 0;
      if (reset) begin
        m_pwr = 0; m_aud = 0; m_age = 0;
        exp_data = '0; exp_gid = '0;
        busy_start = 0; busy_end = 0;
        idle_from = cyc + 1;
        exp_q.delete();
      end else begin
        if (!exp_valid && cyc >= idle_from && (m_pwr || m_aud || kb_ready)) begin
          if (m_pwr) g = 2'd1;
`ifdef TX_SCHED_STARVE_GUARD_EN
          else if (m_aud && !(kb_ready && m_age >= LIMIT)) begin
            g = 2'd2;
            if (kb_ready) m_age++;
          end
`else
          else if (m_aud) g = 2'd2;
`endif
          else begin
            g = 2'd3;
            m_age = 0;
          end
          nv = 1;
          exp_gid = g;
          exp_data = packet_of(g, kb_is_mouse, kb_data);
          exp_q.push_back(exp_data);
        end
        if (power_on) m_pwr = 1;
        if (audio_req) m_aud = 1;
      end
      exp_valid = nv;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input bit aud, input bit pwr, input bit rst);
    @(posedge mon_clk);
    #1;
    audio_req = aud;
    power_on  = pwr;
    reset     = rst;
    send_busy = (cyc >= busy_start) && (cyc < busy_end);
    if (kb_pop) begin
      kb_pop   = 0;
      kb_ready = 0;
      kb_cool  = int'($urandom_range(1, 60));
    end else if (kb_auto && !kb_ready) begin
      if (kb_cool > 0) kb_cool--;
      else begin
        kb_ready    = 1;
        kb_data     = 16'($urandom);
        kb_is_mouse = 1'($urandom);
      end
    end
  endtask

  task automatic wait_recs(input int n, input int budget, input string name);
    for (int i = 0; i < budget && rec_cyc.size() < n; i++) tick(0, 0, 0);
    chk(name, (rec_cyc.size() >= n), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base, pc, t0;
    logic [1:0] e_exp [6];
    reset = 1; audio_req = 0; power_on = 0; kb_ready = 0;
    kb_is_mouse = 0; kb_data = '0; send_busy = 0;

    repeat (3) tick(0, 0, 1);
    tick(0, 0, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_kb_retrieved", kb_retrieved, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_grant_id", grant_id, 0);
    repeat (3) tick(0, 0, 0);

    // power-on and audio in the same cycle, sender busy for 40 cycles starting 2 after launch
    plan_mode = 1; plan_s = 2; plan_len = 40;
    base = rec_cyc.size();
    tick(1, 1, 0);
    pc = cyc;
    wait_recs(base + 2, 300, "b_two_launches");
    if (rec_cyc.size() >= base + 2) begin
      chk("b_latency", rec_cyc[base] - pc, 2);
      chk("b_first_gid", rec_gid[base], 2'd1);
      chk("b_first_data", rec_data[base], 40'hC000000000);
      chk("b_second_gid", rec_gid[base+1], 2'd2);
      chk("b_second_data", rec_data[base+1], 40'h0700000000);
      chk("b_spacing", rec_cyc[base+1] - rec_cyc[base], 84);
    end
    repeat (100) tick(0, 0, 0);

    // sender never reports busy: start timeout then gap
    plan_mode = 2;
    base = rec_cyc.size();
    tick(1, 0, 0);
    wait_recs(base + 1, 100, "c_first_launch");
    tick(1, 0, 0);
    wait_recs(base + 2, 200, "c_second_launch");
    if (rec_cyc.size() >= base + 2)
      chk("c_timeout_spacing", rec_cyc[base+1] - rec_cyc[base], N + 10);
    repeat (80) tick(0, 0, 0);

    // keyboard word from the mouse
    plan_mode = 1; plan_s = 1; plan_len = 5;
    base = rec_cyc.size();
    kb_is_mouse = 1; kb_data = 16'hA55A; kb_ready = 1;
    wait_recs(base + 1, 100, "d_kb_launch");
    if (rec_cyc.size() >= base + 1) begin
      chk("d_kb_data", rec_data[base], 40'hC501A55A00);
      chk("d_kb_gid", rec_gid[base], 2'd3);
      chk("d_kb_retrieved", rec_kbr[base], 1);
    end
    repeat (120) tick(0, 0, 0);
    chk("d_single_launch", rec_cyc.size(), base + 1);

    // audio held pending while keyboard waits
    plan_mode = 1; plan_s = 1; plan_len = 2;
    base = rec_cyc.size();
`ifdef TX_SCHED_STARVE_GUARD_EN
    e_exp = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2};
`else
    e_exp = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
`endif
    tick(1, 0, 0);
    tick(1, 0, 0);
    kb_is_mouse = 0; kb_data = 16'h1234; kb_ready = 1;
    t0 = 0;
    while (rec_cyc.size() < base + 6 && t0 < 700) begin
      tick(1, 0, 0);
      t0++;
    end
    chk("e_six_launches", (rec_cyc.size() >= base + 6), 1);
    if (rec_cyc.size() >= base + 6)
      for (int i = 0; i < 6; i++) chk($sformatf("e_grant_%0d", i), rec_gid[base+i], e_exp[i]);
    repeat (250) tick(0, 0, 0);
    kb_ready = 0;
    repeat (60) tick(0, 0, 0);

    // reset in WAIT_DONE with audio pending; pulses coincident with reset are dropped
    plan_mode = 1; plan_s = 1; plan_len = 30;
    base = rec_cyc.size();
    tick(1, 0, 0);
    wait_recs(base + 1, 100, "f_launch");
    tick(1, 0, 0);
    repeat (5) tick(0, 0, 0);
    chk("f_in_wait_done", dbg_state, WAIT_DONE);
    tick(1, 1, 1);
    tick(0, 0, 0);
    chk("f_rst_out_valid", out_valid, 0);
    chk("f_rst_kb_retrieved", kb_retrieved, 0);
    chk("f_rst_out_data", out_data, 0);
    chk("f_rst_grant_id", grant_id, 0);
    repeat (150) tick(0, 0, 0);
    chk("f_no_launch", rec_cyc.size(), base + 1);

    // random traffic
    plan_mode = 0; kb_auto = 1; kb_cool = 0;
    for (int i = 0; i < 9000; i++)
      tick($urandom_range(0, 29) == 0, $urandom_range(0, 119) == 0, $urandom_range(0, 2999) == 0);
    kb_auto = 0;
    repeat (400) tick(0, 0, 0);
    chk("random_launches_seen", (rec_cyc.size() > base + 20), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tx_packet_scheduler.md
TX_PACKET_SCHEDULER -- requirements
Module: tx_packet_scheduler

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 40: idle mon_clk cycles enforced between the end of one transmission and the next out_valid.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4: consecutive audio grants tolerated while a keyboard packet waits (guard build only).
REQ-003 SHALL have ports: mon_clk in 1, sole clock; reset in 1, synchronous active-high reset.
REQ-004 SHALL have ports: audio_req in 1, one-cycle pulse, audio sample request pending; power_on in 1, one-cycle pulse, power-on reply pending.
REQ-005 SHALL have ports: kb_ready in 1, level, keyboard/mouse word available; kb_is_mouse in 1, source flag; kb_data in 16, payload.
REQ-006 SHALL have ports: kb_retrieved out 1, one-cycle acknowledge that kb_data was consumed.
REQ-007 SHALL have ports: send_busy in 1, high while the serial sender shifts a packet; out_data out 40, packet word; out_valid out 1, one-cycle launch strobe.
REQ-008 SHALL have port: grant_id out 2, source of the last launch (0 none, 1 power-on, 2 audio, 3 keyboard).

Function
REQ-009 SHALL latch audio_req and power_on into sticky pending flags; a repeat pulse while pending SHALL merge into the one flag.
REQ-010 SHALL treat keyboard as pending whenever kb_ready=1 and no keyboard grant is outstanding.
REQ-011 SHALL implement states IDLE, LAUNCH, WAIT_START, WAIT_DONE, GAP.
REQ-012 IDLE: if any request is pending, select by fixed priority power-on > audio > keyboard, register out_data, go to LAUNCH.
REQ-013 LAUNCH: assert out_valid for exactly one cycle, clear the granted pending flag, update grant_id, go to WAIT_START; for keyboard, pulse kb_retrieved in the same cycle.
REQ-014 WAIT_START: go to WAIT_DONE when send_busy=1; if send_busy stays 0 for 8 cycles, go to GAP (sender absorbed the packet without reporting busy).
REQ-015 WAIT_DONE: go to GAP on send_busy=0.
REQ-016 GAP: count GAP_CYCLES cycles, then go to IDLE; requests arriving in any state other than IDLE SHALL remain pending.
REQ-017 Packet encodings: power-on 40'hC0_0000_0000; audio request 40'h07_0000_0000; keyboard {8'hC5, 7'b0, kb_is_mouse, kb_data, 8'h00}.
REQ-018 out_data SHALL hold its value from LAUNCH until the next LAUNCH.
REQ-019 If power_on and audio_req pulse in the same cycle, both SHALL latch; power-on SHALL be launched first.
REQ-020 The gap counter SHALL be ceil(log2(GAP_CYCLES+1)) bits wide and SHALL never wrap.

Reset
REQ-021 While reset=1, on each mon_clk edge: state IDLE, pending flags 0, out_valid 0, kb_retrieved 0, out_data 0, grant_id 0, counters 0.
REQ-022 Reset asserted mid-transmission SHALL abandon the packet without a further out_valid or kb_retrieved; a request pulse coincident with reset SHALL be dropped.

Configuration
REQ-023 With TX_SCHED_STARVE_GUARD_EN defined: an age counter SHALL increment on each audio grant while keyboard is pending; once it reaches STARVE_LIMIT, the next IDLE selection SHALL choose keyboard over audio (power-on still first); a keyboard grant or reset SHALL clear it.
REQ-024 Without TX_SCHED_STARVE_GUARD_EN: strict fixed priority applies, and no age counter is implemented.

Structure
REQ-025 A shared package SHALL hold the state enum, the grant_id codes, the opcode constants 8'hC0, 8'h07 and 8'hC5, and the 8-cycle start timeout.
REQ-026 A single sub-module, tx_gap_timer (load/count/done), SHALL implement the GAP countdown; all other logic SHALL be flat.

Verification
REQ-027 Single power_on pulse, send_busy high for cycles 2-41 after out_valid -> one out_valid with out_data=40'hC000000000, grant_id=1, next launch no earlier than 40 cycles after send_busy falls.
REQ-028 kb_ready=1, kb_is_mouse=1, kb_data=16'hA55A -> out_data=40'hC501A55A00, kb_retrieved pulses in the out_valid cycle, and no second launch while kb_ready drops.
REQ-029 power_on and audio_req pulsed in the same cycle while idle -> two launches in the order power-on then audio, separated by at least the busy period plus GAP_CYCLES.
REQ-030 Audio pulsed before every launch with kb_ready held -> guard build: keyboard granted after exactly 4 audio grants; non-guard build: keyboard never granted while audio stays pending.
REQ-031 send_busy held 0 after launch -> GAP entered 8 cycles after out_valid, next pending request launched afterwards.
REQ-032 reset asserted in WAIT_DONE with audio pending -> no out_valid for the pending audio, all outputs 0 one cycle after the reset edge.
